// File: rtl/multi_timer_pkg.sv
// Shared register offsets, control bit positions and control-word type for multi_timer.
// No logic here, so no latency.
// No flow control; this package only holds definitions.
package multi_timer_pkg;

    localparam logic [2:0] REG_CNT0  = 3'd0;
    localparam logic [2:0] REG_CNT1  = 3'd1;
    localparam logic [2:0] REG_CNT2  = 3'd2;
    localparam logic [2:0] REG_CNT3  = 3'd3;
    localparam logic [2:0] REG_CTRL  = 3'd4;
    localparam logic [2:0] REG_STAT  = 3'd5;
    localparam logic [2:0] REG_PRESC = 3'd6;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_FLAG = 0;

    // Field order puts run in bit 0, matching the ctrl register layout.
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/multi_timer_channel.sv
// One down-counting timer channel: counter/reload, prescaler, ctrl, sticky flag.
// Register writes take effect on the next clk edge; rd_dat is combinational.
// No backpressure: a write strobe is always accepted in the cycle it is presented.
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] reg_sel,
    input  logic [7:0] wdat,
    input  logic       hsync,
    input  logic       vsync,
    output logic [7:0] rd_dat,
    output logic       irq
);

    localparam int CW = 8 * CNT_BYTES;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rld_q, rld_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [7:0]    presc_q, presc_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          flag_q, flag_d;
    logic          tick;
    logic          expire;
    logic          cnt_wr;

    // Next state: prescaler/tick update first, then CPU writes override counter and run.
    always_comb begin
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        pcnt_d  = pcnt_q;
        presc_d = presc_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
        tick    = 1'b0;
        expire  = 1'b0;
        cnt_wr  = wr_en && ({29'd0, reg_sel} < 32'(CNT_BYTES));

        if (ctrl_q.run) begin
            if (pcnt_q == 8'd0) begin
                tick   = 1'b1;
                pcnt_d = presc_q;
            end else begin
                pcnt_d = pcnt_q - 8'd1;
            end
            // A zero count stops immediately in every mode, so auto-reload cannot spin.
            if (cnt_q == '0) begin
                expire     = 1'b1;
                ctrl_d.run = 1'b0;
            end else if (tick) begin
                if (cnt_q == CW'(1)) begin
                    expire = 1'b1;
                    if (ctrl_q.auto_rl && (rld_q != '0)) begin
                        cnt_d = rld_q;
                    end else begin
                        cnt_d      = '0;
                        ctrl_d.run = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        end

        // Expiry wins over a same-cycle write-1-to-clear.
        if (wr_en && (reg_sel == REG_STAT) && wdat[STAT_FLAG]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end

        if (cnt_wr) begin
            cnt_d      = cnt_q;
            ctrl_d.run = ctrl_q.run;
            for (int k = 0; k < CNT_BYTES; k++) begin
                if (reg_sel == 3'(k)) begin
                    cnt_d[8*k +: 8] = wdat;
                    rld_d[8*k +: 8] = wdat;
                end
            end
            if (reg_sel == REG_CNT0) begin
                ctrl_d.run = 1'b1;
                pcnt_d     = presc_q;
            end
        end else if (wr_en && (reg_sel == REG_CTRL)) begin
            cnt_d          = cnt_q;
            ctrl_d.run     = wdat[CTRL_RUN];
            ctrl_d.auto_rl = wdat[CTRL_AUTO];
            ctrl_d.ie      = wdat[CTRL_IE];
        end else if (wr_en && (reg_sel == REG_PRESC)) begin
            presc_d = wdat;
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rld_q   <= '0;
            pcnt_q  <= 8'd0;
            presc_q <= 8'd0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            pcnt_q  <= pcnt_d;
            presc_q <= presc_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
        end
    end

    // Register read mux; count bytes beyond the counter width read as zero.
    always_comb begin
        rd_dat = 8'h00;
        case (reg_sel)
            REG_CNT0, REG_CNT1, REG_CNT2, REG_CNT3: begin
                for (int k = 0; k < CNT_BYTES; k++) begin
                    if (reg_sel == 3'(k)) begin
                        rd_dat = cnt_q[8*k +: 8];
                    end
                end
            end
            REG_CTRL:  rd_dat = {5'b0, ctrl_q};
            REG_STAT:  rd_dat = {4'b0, ~vsync, ~hsync, |cnt_q, flag_q};
            REG_PRESC: rd_dat = presc_q;
            default:   rd_dat = 8'h00;
        endcase
    end

    assign irq = flag_q & ctrl_q.ie;

endmodule

// File: rtl/multi_timer.sv
// CPU-mapped bank of NUM_CH independent down-counting timers on the 8-bit peripheral bus.
// Writes land on the next clk edge; to_cpu is registered, one cycle after ce & ren.
// No backpressure: every qualified bus access completes in its own cycle.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_BYTES = 3,
    parameter int ADDR_W    = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              wren,
    input  logic              ren,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        from_cpu,
    output logic [7:0]        to_cpu,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              timer_int
);

    localparam int CH_W = ADDR_W - 3;

    logic [CH_W-1:0] ch_sel;
    logic [2:0]      reg_sel;
    logic [7:0]      rd_dat [NUM_CH];
    logic [7:0]      to_cpu_q, to_cpu_d;

    assign ch_sel  = addr[ADDR_W-1:3];
    assign reg_sel = addr[2:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_timer_channel #(
            .CNT_BYTES(CNT_BYTES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (ce && wren && (ch_sel == CH_W'(i))),
            .reg_sel(reg_sel),
            .wdat   (from_cpu),
            .hsync  (hsync),
            .vsync  (vsync),
            .rd_dat (rd_dat[i]),
            .irq    (irq_vec[i])
        );
    end

    // Capture the selected channel's read data only on a qualified read.
    always_comb begin
        to_cpu_d = to_cpu_q;
        if (ce && ren) begin
            to_cpu_d = rd_dat[ch_sel];
        end
    end

    // Read data register; sees pre-write state when a write shares the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cpu_q <= 8'h00;
        end else begin
            to_cpu_q <= to_cpu_d;
        end
    end

    assign to_cpu    = to_cpu_q;
    assign timer_int = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus randomized bus traffic.
// Outputs are compared every cycle against a behavioural model of the register map.
// The bench drives the bus freely; the design has no backpressure.
module tb_multi_timer;

    localparam int NCH = 4;
    localparam int NB  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0, wren = 1'b0, ren = 1'b0;
    logic       hsync = 1'b1, vsync = 1'b1;
    logic [4:0] addr = 5'd0;
    logic [7:0] from_cpu = 8'd0;
    logic [7:0] to_cpu;
    logic [NCH-1:0] irq_vec;
    logic       timer_int;

    int n_checks = 0;
    int n_fail   = 0;

    multi_timer #(.NUM_CH(NCH), .CNT_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .ce(ce), .wren(wren), .ren(ren),
        .hsync(hsync), .vsync(vsync), .addr(addr), .from_cpu(from_cpu),
        .to_cpu(to_cpu), .irq_vec(irq_vec), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    // Behavioural model state, one entry per channel.
    int m_cnt[NCH], m_rld[NCH], m_pcnt[NCH], m_presc[NCH];
    bit m_run[NCH], m_auto[NCH], m_ie[NCH], m_flag[NCH];
    int m_to_cpu = 0;
    bit model_live = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_read(input int c, input int r);
        case (r)
            0, 1, 2, 3: return (r < NB) ? ((m_cnt[c] >> (8 * r)) & 255) : 0;
            4: return (m_ie[c] ? 4 : 0) + (m_auto[c] ? 2 : 0) + (m_run[c] ? 1 : 0);
            5: return (vsync ? 0 : 8) + (hsync ? 0 : 4) + ((m_cnt[c] != 0) ? 2 : 0) + (m_flag[c] ? 1 : 0);
            6: return m_presc[c];
            default: return 0;
        endcase
    endfunction

    function automatic void m_step(input int i, input bit w, input int r, input int d);
        int ncnt  = m_cnt[i];
        int npcnt = m_pcnt[i];
        bit nrun  = m_run[i];
        bit nflag = m_flag[i];
        bit tick  = 0;
        bit expire = 0;
        if (m_run[i]) begin
            tick  = (m_pcnt[i] == 0);
            npcnt = tick ? m_presc[i] : m_pcnt[i] - 1;
            if (m_cnt[i] == 0) begin
                expire = 1; nrun = 0;
            end else if (tick && m_cnt[i] > 1) begin
                ncnt = m_cnt[i] - 1;
            end else if (tick) begin
                expire = 1;
                if (m_auto[i] && m_rld[i] != 0) ncnt = m_rld[i];
                else begin ncnt = 0; nrun = 0; end
            end
        end
        if (w && r == 5 && d[0]) nflag = 0;
        if (expire) nflag = 1;
        if (w && r < NB) begin
            int sh;
            sh = 8 * r;
            ncnt     = (m_cnt[i] & ~(255 << sh)) | (d << sh);
            m_rld[i] = (m_rld[i] & ~(255 << sh)) | (d << sh);
            nrun     = (r == 0) ? 1'b1 : m_run[i];
            if (r == 0) npcnt = m_presc[i];
        end else if (w && r == 4) begin
            ncnt = m_cnt[i];
            nrun = d[0]; m_auto[i] = d[1]; m_ie[i] = d[2];
        end else if (w && r == 6) begin
            m_presc[i] = d;
        end
        m_cnt[i] = ncnt; m_pcnt[i] = npcnt; m_run[i] = nrun; m_flag[i] = nflag;
    endfunction

    // Advance the model on each rising edge using the inputs the DUT samples.
    always @(posedge clk) begin
        model_live = 1;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i] = 0; m_rld[i] = 0; m_pcnt[i] = 0; m_presc[i] = 0;
                m_run[i] = 0; m_auto[i] = 0; m_ie[i] = 0; m_flag[i] = 0;
            end
            m_to_cpu = 0;
        end else begin
            if (ce && ren) m_to_cpu = m_read(int'(addr[4:3]), int'(addr[2:0]));
            for (int i = 0; i < NCH; i++)
                m_step(i, ce && wren && (int'(addr[4:3]) == i), int'(addr[2:0]), int'(from_cpu));
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : cmp
        int exp_irq;
        if (model_live) begin
            exp_irq = 0;
            for (int i = 0; i < NCH; i++)
                if (m_flag[i] && m_ie[i]) exp_irq = exp_irq | (1 << i);
            chk("to_cpu", int'(to_cpu), m_to_cpu);
            chk("irq_vec", int'(irq_vec), exp_irq);
            chk("timer_int", int'(timer_int), (exp_irq != 0) ? 1 : 0);
        end
    end

    task automatic bus(input bit w, input bit r, input int c, input int rg, input int d);
        @(posedge clk); #1;
        ce = 1'b1; wren = w; ren = r; addr = 5'(c * 8 + rg); from_cpu = 8'(d);
    endtask

    task automatic wr(input int c, input int rg, input int d);
        bus(1'b1, 1'b0, c, rg, d);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic rd_chk(input string name, input int c, input int rg, input int exp);
        bus(1'b0, 1'b1, c, rg, 0);
        idle(1);
        chk(name, int'(to_cpu), exp);
    endtask

    initial begin
        int c, rg, d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        chk("reset_to_cpu", int'(to_cpu), 0);
        chk("reset_irq_vec", int'(irq_vec), 0);
        chk("reset_timer_int", int'(timer_int), 0);

        // One-shot, ch0: count 5, presc 0 -> flag exactly 5 cycles after byte-0 write.
        wr(0, 4, 4); wr(0, 1, 0); wr(0, 0, 5);
        idle(5); chk("oneshot_early", int'(irq_vec[0]), 0);
        idle(1); chk("oneshot_irq", int'(irq_vec[0]), 1);
        chk("oneshot_model_flag", int'(m_flag[0]), 1);
        rd_chk("oneshot_cnt", 0, 0, 0);
        rd_chk("oneshot_ctrl", 0, 4, 8'h04);
        wr(0, 5, 1); idle(1); chk("w1c_clear", int'(irq_vec[0]), 0);

        // Auto-reload, ch1: reload 3, presc 1 -> expiry every 6 cycles.
        wr(1, 6, 1); wr(1, 4, 6); wr(1, 1, 0); wr(1, 0, 3);
        idle(6); chk("auto_early", int'(irq_vec[1]), 0);
        idle(1); chk("auto_first", int'(irq_vec[1]), 1);
        wr(1, 5, 1); idle(1); chk("auto_w1c", int'(irq_vec[1]), 0);
        idle(2); wr(1, 5, 1); idle(1);
        chk("auto_w1c_vs_expiry", int'(irq_vec[1]), 1);
        chk("auto_model_cnt", m_cnt[1], 3);
        wr(1, 4, 0); wr(1, 5, 1); idle(1); chk("auto_stopped", int'(irq_vec[1]), 0);

        // Pause/resume, ch2: presc 4, count 10, pause after 2 ticks.
        wr(2, 6, 4); wr(2, 4, 4); wr(2, 1, 0); wr(2, 0, 10);
        idle(10); wr(2, 4, 4);
        idle(20);
        rd_chk("pause_hold", 2, 0, 8);
        wr(2, 4, 5);
        idle(39); chk("resume_early", int'(irq_vec[2]), 0);
        idle(1);  chk("resume_expiry", int'(irq_vec[2]), 1);
        wr(2, 5, 1); idle(1);

        // Zero start, ch3 with auto set: single expiry one cycle later.
        wr(3, 4, 6); wr(3, 1, 0); wr(3, 0, 0);
        idle(1); chk("zero_early", int'(irq_vec[3]), 0);
        idle(1); chk("zero_flag", int'(irq_vec[3]), 1);
        rd_chk("zero_run_off", 3, 4, 8'h06);
        wr(3, 5, 1); idle(10); chk("zero_no_repeat", int'(irq_vec[3]), 0);

        // Status and sparse registers; ctrl write beats a same-cycle tick.
        hsync = 1'b0; vsync = 1'b1;
        wr(0, 0, 7); wr(0, 4, 0);
        rd_chk("status_read", 0, 5, 8'h06);
        rd_chk("ctrl_beats_tick", 0, 0, 7);
        rd_chk("reg7_zero", 0, 7, 0);
        wr(0, 2, 8'hff);
        rd_chk("byte2_absent", 0, 2, 0);
        rd_chk("byte3_absent", 0, 3, 0);
        hsync = 1'b1;

        // Reset mid-count aborts without an expiry.
        wr(0, 4, 4); wr(0, 0, 100); idle(20);
        rst = 1'b1; idle(1);
        chk("reset_mid_int", int'(timer_int), 0);
        rst = 1'b0;
        idle(150); chk("reset_no_expiry", int'(timer_int), 0);
        rd_chk("reset_cnt", 0, 0, 0);
        rd_chk("reset_ctrl", 0, 4, 0);

        // Randomized traffic checked by the per-cycle model comparison.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 599) == 0);
            ce    = ($urandom_range(0, 9) != 0);
            wren  = ($urandom_range(0, 3) == 0);
            ren   = ($urandom_range(0, 1) == 0);
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            c  = int'($urandom_range(0, NCH - 1));
            rg = int'($urandom_range(0, 7));
            case (rg)
                0: d = int'($urandom_range(0, 8));
                1: d = ($urandom_range(0, 7) == 0) ? 1 : 0;
                4: d = int'($urandom_range(0, 7));
                6: d = int'($urandom_range(0, 3));
                default: d = int'($urandom_range(0, 255));
            endcase
            addr = 5'(c * 8 + rg);
            from_cpu = 8'(d);
        end
        rst = 1'b0;
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
